apb_slave_bank: RTL and testbench
=================================

APB_SLAVE_BANK -- requirements
Module: apb_slave_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32: PWdata/PRdata width.
REQ-002 SHALL have parameter ADDR_W, default 32: Paddr width.
REQ-003 SHALL have parameter NUM_SLV, default 3: number of slaves, one Pselx bit each.
REQ-004 SHALL have parameter DEPTH, default 16: words per slave, power of two.
REQ-005 SHALL have parameter WAIT_CYC, default 0: PREADY-low cycles inserted per access phase, range 0..15.
REQ-006 SHALL have port Hclk, input, 1: single clock, rising edge.
REQ-007 SHALL have port Hreset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port Pselx, input, NUM_SLV: one-hot slave select.
REQ-009 SHALL have port Penable, input, 1: APB access phase.
REQ-010 SHALL have port Pwrite, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port Paddr, input, ADDR_W: byte address; word index = Paddr[log2(DEPTH)+1:2].
REQ-012 SHALL have port PWdata, input, DATA_W: write data.
REQ-013 SHALL have port PRdata, output, DATA_W: read data.
REQ-014 SHALL have port Pready, output, 1: transfer completes when high.
REQ-015 SHALL have port Pslverr, output, 1: error response, qualified by Pready.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP, WAIT, ACCESS.
REQ-017 IDLE->SETUP SHALL occur when any Pselx bit is set and Penable=0.
REQ-018 In SETUP, the FSM SHALL latch Pselx, Pwrite, word index and PWdata.
REQ-019 SETUP SHALL go to WAIT if WAIT_CYC>0, else to ACCESS.
REQ-020 WAIT SHALL hold Pready=0 for exactly WAIT_CYC cycles using a down-counter, then go to ACCESS.
REQ-021 ACCESS SHALL drive Pready=1 for exactly one cycle.
REQ-022 After ACCESS, the FSM SHALL go to SETUP if Pselx is set and Penable=0 (back-to-back), else to IDLE.
REQ-023 Writes SHALL commit to mem[slave][index] on the ACCESS clock edge.
REQ-024 A read SHALL drive PRdata = stored word during ACCESS, and PRdata=0 in all other states.
REQ-025 Read latency SHALL be 2+WAIT_CYC cycles from SETUP entry to Pready high.
REQ-026 Pready SHALL be 0 in IDLE, SETUP and WAIT.
REQ-027 A Pselx value with more than one bit set in SETUP SHALL be an error: no write, PRdata=0, transfer still completes.
REQ-028 Address bits above the word index SHALL be ignored, so addresses alias/wrap modulo DEPTH*4.
REQ-029 A Penable drop or Pselx change during WAIT SHALL not abort the transfer; the latched values are used.

Reset
REQ-030 Hreset high at a clock edge SHALL force IDLE, clear the wait counter, and drive Pready=0, Pslverr=0, PRdata=0.
REQ-031 Reset SHALL zero all memory words.
REQ-032 Reset asserted during WAIT or ACCESS SHALL drop the transfer; a pending write SHALL not commit.

Configuration
REQ-033 With APB_SLVERR_EN defined, Pslverr SHALL be 1 during ACCESS for a multi-bit Pselx or for Paddr[1:0]!=0; such writes are suppressed and PRdata=0.
REQ-034 Without APB_SLVERR_EN, Pslverr SHALL be tied 0, misaligned addresses SHALL be truncated to the word index, and a multi-bit select SHALL behave per REQ-027 silently.

Structure
REQ-035 Package apb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-036 One sub-module, apb_slave_mem (DEPTH x DATA_W, one write port, one read port), SHALL be instantiated NUM_SLV times.

Verification
REQ-037 WAIT_CYC=0: write 0xDEADBEEF to slave 1 at addr 0x08, then read it back -> Pready on 2nd cycle of each transfer, PRdata=0xDEADBEEF.
REQ-038 WAIT_CYC=3: single read -> Pready low for 3 WAIT cycles, high on cycle 5, PRdata=0 for an unwritten word.
REQ-039 Write 0x1 to addr 0x00, then 0x2 to addr 0x40 (DEPTH=16) -> reading 0x00 returns 0x2 (wrap).
REQ-040 Pselx=3'b011 write with APB_SLVERR_EN -> Pslverr=1 with Pready, neither slave modified; without the macro -> Pslverr=0, neither slave modified.
REQ-041 Hreset pulsed during WAIT of a write of 0x55 -> FSM in IDLE next cycle, subsequent read returns 0.
REQ-042 Back-to-back writes to slaves 0 and 2 with no idle cycle -> both commit, FSM never enters IDLE between them.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared state encoding and default parameter values for the
//               APB slave bank.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int c_def_data_w   = 32;
    localparam int c_def_addr_w   = 32;
    localparam int c_def_num_slv  = 3;
    localparam int c_def_depth    = 16;
    localparam int c_def_wait_cyc = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : DEPTH x DATA_W register file, one write port, one
//               asynchronous read port, cleared by synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_bank
// Description : APB slave with NUM_SLV memory banks and WAIT_CYC wait states.
//               Optional error response enabled by define APB_SLVERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_bank
    import apb_pkg::*;
#(
    parameter int DATA_W   = c_def_data_w,
    parameter int ADDR_W   = c_def_addr_w,
    parameter int NUM_SLV  = c_def_num_slv,
    parameter int DEPTH    = c_def_depth,
    parameter int WAIT_CYC = c_def_wait_cyc
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [ADDR_W-1:0]  Paddr,
    input  logic [DATA_W-1:0]  PWdata,
    output logic [DATA_W-1:0]  PRdata,
    output logic               Pready,
    output logic               Pslverr
);

    localparam int         c_idx_w     = $clog2(DEPTH);
    localparam logic [3:0] c_wait_load = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    apb_state_t           r_state;
    apb_state_t           w_next;
    logic [NUM_SLV-1:0]   r_sel;
    logic                 r_write;
    logic [c_idx_w-1:0]   r_idx;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_err;
    logic [3:0]           r_cnt;

    logic                 w_req;
    logic                 w_multi;
    logic                 w_misalign;
    logic                 w_commit;
    logic [DATA_W-1:0]    w_rd [NUM_SLV];
    logic [DATA_W-1:0]    w_rd_mux;
    logic                 w_unused_addr;

    assign w_req   = (|Pselx) && !Penable;
    assign w_multi = |(Pselx & (Pselx - NUM_SLV'(1)));

`ifdef APB_SLVERR_EN
    assign w_misalign = |Paddr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // Upper address bits alias; low byte-lane bits only matter for the error check.
    assign w_unused_addr = ^{Paddr[ADDR_W-1:c_idx_w+2], Paddr[1:0]};

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_next = ST_SETUP;
            ST_SETUP:  w_next = (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (r_cnt == 4'd0) w_next = ST_ACCESS;
            ST_ACCESS: w_next = w_req ? ST_SETUP : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_sel   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (r_state == ST_SETUP) begin
            r_sel   <= Pselx;
            r_write <= Pwrite;
            r_idx   <= Paddr[c_idx_w+1:2];
            r_wdata <= PWdata;
            r_err   <= w_multi || w_misalign;
            r_cnt   <= c_wait_load;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Commit only on the ACCESS edge so a reset during WAIT drops the write.
    assign w_commit = (r_state == ST_ACCESS) && r_write && !r_err;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
        apb_slave_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (c_idx_w)
        ) u_mem (
            .clk   (Hclk),
            .rst   (Hreset),
            .we    (w_commit && r_sel[g]),
            .waddr (r_idx),
            .wdata (r_wdata),
            .raddr (r_idx),
            .rdata (w_rd[g])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_sel[i]) w_rd_mux = w_rd_mux | w_rd[i];
        end
    end

    assign Pready = (r_state == ST_ACCESS);
    assign PRdata = ((r_state == ST_ACCESS) && !r_write && !r_err) ? w_rd_mux : '0;

`ifdef APB_SLVERR_EN
    assign Pslverr = (r_state == ST_ACCESS) && r_err;
`else
    assign Pslverr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_bank
// Description : Directed self-checking bench; one instance with no wait
//               states and one with three, sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_bank;

`ifdef APB_SLVERR_EN
    localparam logic c_err_on = 1'b1;
`else
    localparam logic c_err_on = 1'b0;
`endif

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    int          r_tgt;

    logic [2:0]  w_psel0, w_psel3;
    logic [31:0] w_rdata0, w_rdata3;
    logic        w_ready0, w_ready3, w_err0, w_err3;
    logic [31:0] w_rdata;
    logic        w_ready, w_err;

    int n_chk  = 0;
    int n_pass = 0;

    assign w_psel0 = (r_tgt == 0) ? r_psel : 3'b000;
    assign w_psel3 = (r_tgt == 1) ? r_psel : 3'b000;
    assign w_rdata = (r_tgt == 0) ? w_rdata0 : w_rdata3;
    assign w_ready = (r_tgt == 0) ? w_ready0 : w_ready3;
    assign w_err   = (r_tgt == 0) ? w_err0   : w_err3;

    apb_slave_bank #(.WAIT_CYC(0)) u_dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(w_psel0), .Penable(r_penable),
        .Pwrite(r_pwrite), .Paddr(r_paddr), .PWdata(r_pwdata),
        .PRdata(w_rdata0), .Pready(w_ready0), .Pslverr(w_err0)
    );

    apb_slave_bank #(.WAIT_CYC(3)) u_dut3 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(w_psel3), .Penable(r_penable),
        .Pwrite(r_pwrite), .Paddr(r_paddr), .PWdata(r_pwdata),
        .PRdata(w_rdata3), .Pready(w_ready3), .Pslverr(w_err3)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Cycle 1 is the SETUP-state cycle; returns the cycle on which Pready rose.
    task automatic xfer(input int t, input logic [2:0] sel, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge Hclk);
        r_tgt = t; r_psel = sel; r_penable = 1'b0; r_pwrite = wr;
        r_paddr = addr; r_pwdata = data;
        @(negedge Hclk);
        r_penable = 1'b1;
        lat = 1;
        while (!w_ready && lat < 40) begin
            @(negedge Hclk);
            lat++;
        end
        rd  = w_rdata;
        err = w_err;
        r_psel = 3'b000; r_penable = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input int t, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd; logic err; int lat;
        xfer(t, sel, 1'b1, addr, data, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), (t == 0) ? 32'd2 : 32'd5);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input int t, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd; logic err; int lat;
        xfer(t, sel, 1'b0, addr, 32'd0, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), (t == 0) ? 32'd2 : 32'd5);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        Hreset = 1'b1; r_tgt = 0; r_psel = 3'b000; r_penable = 1'b0;
        r_pwrite = 1'b0; r_paddr = 32'd0; r_pwdata = 32'd0;
        repeat (2) @(negedge Hclk);
        check("rst_ready0", {31'd0, w_ready0}, 32'd0);
        check("rst_err0",   {31'd0, w_err0},   32'd0);
        check("rst_rdata0", w_rdata0, 32'd0);
        check("rst_ready3", {31'd0, w_ready3}, 32'd0);
        Hreset = 1'b0;

        // Basic write/read, zero wait states
        wr_chk("wr_s1_08", 0, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0);
        rd_chk("rd_s1_08", 0, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0);
        rd_chk("rd_s0_08", 0, 3'b001, 32'h08, 32'h0, 1'b0);

        // Address wrap modulo DEPTH*4
        wr_chk("wr_s0_00", 0, 3'b001, 32'h00, 32'h1, 1'b0);
        wr_chk("wr_s0_40", 0, 3'b001, 32'h40, 32'h2, 1'b0);
        rd_chk("rd_wrap",  0, 3'b001, 32'h00, 32'h2, 1'b0);

        // Multi-bit select: no write to either slave
        wr_chk("wr_s0_0c", 0, 3'b001, 32'h0C, 32'hA, 1'b0);
        wr_chk("wr_s1_0c", 0, 3'b010, 32'h0C, 32'hB, 1'b0);
        wr_chk("wr_multi", 0, 3'b011, 32'h0C, 32'hFFFFFFFF, c_err_on);
        rd_chk("rd_s0_0c", 0, 3'b001, 32'h0C, 32'hA, 1'b0);
        rd_chk("rd_s1_0c", 0, 3'b010, 32'h0C, 32'hB, 1'b0);
        rd_chk("rd_multi", 0, 3'b011, 32'h0C, 32'h0, c_err_on);

        // Misaligned address: error or truncation depending on build
        wr_chk("wr_misal", 0, 3'b100, 32'h22, 32'h77, c_err_on);
        rd_chk("rd_misal", 0, 3'b100, 32'h20, c_err_on ? 32'h0 : 32'h77, 1'b0);

        // Back-to-back writes with no idle state between
        @(negedge Hclk);
        r_tgt = 0; r_psel = 3'b001; r_penable = 1'b0; r_pwrite = 1'b1;
        r_paddr = 32'h04; r_pwdata = 32'h11111111;
        @(negedge Hclk);
        check("b2b_setup1", {31'd0, w_ready0}, 32'd0);
        r_penable = 1'b1;
        @(negedge Hclk);
        check("b2b_acc1", {31'd0, w_ready0}, 32'd1);
        r_psel = 3'b100; r_penable = 1'b0; r_paddr = 32'h14; r_pwdata = 32'h22222222;
        @(negedge Hclk);
        check("b2b_setup2", {31'd0, w_ready0}, 32'd0);
        r_penable = 1'b1;
        @(negedge Hclk);
        check("b2b_acc2", {31'd0, w_ready0}, 32'd1);
        r_psel = 3'b000; r_penable = 1'b0;
        rd_chk("rd_b2b_s0", 0, 3'b001, 32'h04, 32'h11111111, 1'b0);
        rd_chk("rd_b2b_s2", 0, 3'b100, 32'h14, 32'h22222222, 1'b0);

        // Three wait states
        rd_chk("rd3_unwr", 1, 3'b100, 32'h3C, 32'h0, 1'b0);
        wr_chk("wr3_s2",   1, 3'b100, 32'h3C, 32'hCAFEF00D, 1'b0);
        rd_chk("rd3_s2",   1, 3'b100, 32'h3C, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a waited write
        @(negedge Hclk);
        r_tgt = 1; r_psel = 3'b001; r_penable = 1'b0; r_pwrite = 1'b1;
        r_paddr = 32'h10; r_pwdata = 32'h55;
        @(negedge Hclk);
        r_penable = 1'b1;
        @(negedge Hclk);
        check("rstw_wait_ready", {31'd0, w_ready3}, 32'd0);
        Hreset = 1'b1; r_psel = 3'b000; r_penable = 1'b0;
        @(negedge Hclk);
        Hreset = 1'b0;
        check("rstw_ready", {31'd0, w_ready3}, 32'd0);
        check("rstw_rdata", w_rdata3, 32'd0);
        rd_chk("rd3_after_rst", 1, 3'b001, 32'h10, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
